// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter: a small byte FIFO feeds a baud-timed serialiser.
// tx and tx_busy are registered from the FSM state, so both lag the state by one cycle.
module uart_tx_buf #(
    parameter int UART_BPS   = 9600,
    parameter int CLK_FREQ   = 50_000_000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic [7:0]                    pi_data,
    input  logic                          pi_flag,
    output logic                          tx,
    output logic                          tx_busy,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int          AW           = $clog2(FIFO_DEPTH);
    localparam int          BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam logic [15:0] BAUD_LAST    = 16'(BAUD_CNT_MAX - 1);
    localparam logic [AW:0] LEVEL_FULL   = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t         state_q, state_d;
    logic [15:0]    baud_q, baud_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     shift_q, shift_d;
    logic           tx_q, tx_d;
    logic           busy_q;
    logic           ovf_q;
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [AW:0]    level_q;
    logic [7:0]     mem [FIFO_DEPTH];

    logic full, empty, push, pop, bit_end;

    // Fullness is taken from the registered level, so a write in a pop cycle while full is dropped.
    assign full    = (level_q == LEVEL_FULL);
    assign empty   = (level_q == '0);
    assign push    = pi_flag && !full;
    assign bit_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        tx_d    = 1'b1;
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr_q];
                    state_d = S_START;
                end
            end
            S_START: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            S_DATA: begin
                tx_d = shift_q[0];
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when more data is queued.
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr_q];
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= (state_q != S_IDLE);
            ovf_q   <= pi_flag && full;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem[wr_ptr_q] <= pi_data;
        end
    end

    assign tx         = tx_q;
    assign tx_busy    = busy_q;
    assign fifo_full  = full;
    assign fifo_level = level_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_uart_tx_buf.sv
// Bench for uart_tx_buf: directed writes push expected bytes into a queue, and an
// independent line receiver decodes tx frames and compares them against that queue.
module tb_uart_tx_buf;

    localparam int CLK_FREQ   = 1_000_000;
    localparam int UART_BPS   = 100_000;
    localparam int FIFO_DEPTH = 4;
    localparam int BIT_CYC    = 10;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [7:0] pi_data = 8'h00;
    logic       pi_flag = 1'b0;
    logic       tx, tx_busy, fifo_full, overflow;
    logic [2:0] fifo_level;

    int n_vec = 0, n_err = 0;
    int cyc = 0, busy_cnt = 0, ov_cnt = 0, low_cnt = 0, rst_cnt = 0;
    logic [7:0] exp_q [$];
    bit mon_busy = 1'b0;

    uart_tx_buf #(
        .UART_BPS   (UART_BPS),
        .CLK_FREQ   (CLK_FREQ),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .pi_data    (pi_data),
        .pi_flag    (pi_flag),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .fifo_full  (fifo_full),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        cyc <= cyc + 1;
        if (sys_rst) rst_cnt <= rst_cnt + 1;
    end

    always @(negedge sys_clk) begin
        busy_cnt <= busy_cnt + (tx_busy ? 1 : 0);
        ov_cnt   <= ov_cnt + (overflow ? 1 : 0);
        low_cnt  <= low_cnt + ((tx === 1'b0) ? 1 : 0);
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        repeat (3) @(negedge sys_clk);
        while ((tx_busy || fifo_level != 0 || mon_busy) && k < budget) begin
            @(negedge sys_clk);
            k++;
        end
        check({name, "_idle_timeout"}, (k >= budget) ? 1 : 0, 0);
    endtask

    // Line receiver: mid-bit sampling; frames cut by a reset are discarded.
    initial begin : monitor
        logic [7:0] d;
        logic       startb, stopb;
        int         r0;
        forever begin
            @(negedge sys_clk);
            if (!sys_rst && tx === 1'b0) begin
                mon_busy = 1'b1;
                r0 = rst_cnt;
                repeat (BIT_CYC / 2) @(negedge sys_clk);
                startb = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT_CYC) @(negedge sys_clk);
                    d[i] = tx;
                end
                repeat (BIT_CYC) @(negedge sys_clk);
                stopb = tx;
                if (rst_cnt == r0) begin
                    check("start_bit", int'(startb), 0);
                    check("stop_bit", int'(stopb), 1);
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_frame: got %02h expected none", d);
                    end else begin
                        check("frame_data", int'(d), int'(exp_q.pop_front()));
                    end
                end
                mon_busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int  b0, o0, l0, n, k;
        bit  act;

        repeat (3) @(negedge sys_clk);
        check("rst_tx", int'(tx), 1);
        check("rst_busy", int'(tx_busy), 0);
        check("rst_full", int'(fifo_full), 0);
        check("rst_level", int'(fifo_level), 0);
        check("rst_overflow", int'(overflow), 0);
        sys_rst = 1'b0;

        act = 1'b0;
        for (int i = 0; i < 20; i++) begin
            pi_data = 8'($urandom);
            @(negedge sys_clk);
            if (tx !== 1'b1 || tx_busy || fifo_level != 0 || overflow) act = 1'b1;
        end
        check("no_activity_without_flag", int'(act), 0);

        // Single byte 0x55 from idle
        b0 = busy_cnt;
        @(negedge sys_clk);
        pi_flag = 1'b1; pi_data = 8'h55; exp_q.push_back(8'h55);
        @(negedge sys_clk);
        pi_flag = 1'b0;
        check("t1_level_after_write", int'(fifo_level), 1);
        check("t1_tx_idle", int'(tx), 1);
        @(negedge sys_clk);
        check("t1_level_after_pop", int'(fifo_level), 0);
        check("t1_busy_before_start", int'(tx_busy), 0);
        check("t1_tx_before_start", int'(tx), 1);
        @(negedge sys_clk);
        check("t1_tx_start", int'(tx), 0);
        check("t1_busy_start", int'(tx_busy), 1);
        wait_idle("t1", 300);
        check("t1_busy_cycles", busy_cnt - b0, 100);

        // Two bytes back to back
        b0 = busy_cnt;
        @(negedge sys_clk);
        pi_flag = 1'b1; pi_data = 8'hA3; exp_q.push_back(8'hA3);
        @(negedge sys_clk);
        pi_data = 8'h3C; exp_q.push_back(8'h3C);
        @(negedge sys_clk);
        pi_flag = 1'b0;
        wait_idle("t2", 500);
        check("t2_busy_cycles", busy_cnt - b0, 200);

        // Six writes: fill, overflow, then a dropped write on the STOP->START pop
        b0 = busy_cnt;
        o0 = ov_cnt;
        n  = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge sys_clk);
            if (i == 0) n = cyc + 1;
            if (i == 5) begin
                check("t3_full", int'(fifo_full), 1);
                check("t3_level_full", int'(fifo_level), 4);
            end
            pi_flag = 1'b1;
            pi_data = 8'(i + 1);
            if (i < 5) exp_q.push_back(8'(i + 1));
        end
        @(negedge sys_clk);
        pi_flag = 1'b0;
        check("t3_overflow_pulse", int'(overflow), 1);
        check("t3_level_after_drop", int'(fifo_level), 4);
        @(negedge sys_clk);
        check("t3_overflow_clear", int'(overflow), 0);

        k = 0;
        while (cyc < n + 100 && k < 200) begin
            @(negedge sys_clk);
            k++;
        end
        check("t4_reach_pop_cycle", cyc, n + 100);
        check("t4_level_before", int'(fifo_level), 4);
        check("t4_full_before", int'(fifo_full), 1);
        pi_flag = 1'b1; pi_data = 8'h77;
        @(negedge sys_clk);
        pi_flag = 1'b0;
        check("t4_overflow", int'(overflow), 1);
        check("t4_level_after", int'(fifo_level), 3);
        check("t4_full_after", int'(fifo_full), 0);
        check("t4_busy", int'(tx_busy), 1);
        wait_idle("t3", 800);
        check("t3_busy_cycles", busy_cnt - b0, 500);
        check("t3_overflow_count", ov_cnt - o0, 2);

        // Reset mid-DATA of 0xF0 with two bytes queued
        @(negedge sys_clk);
        pi_flag = 1'b1; pi_data = 8'hF0;
        @(negedge sys_clk);
        pi_data = 8'h11;
        @(negedge sys_clk);
        pi_data = 8'h22;
        @(negedge sys_clk);
        pi_flag = 1'b0;
        check("t5_level_queued", int'(fifo_level), 2);
        repeat (40) @(negedge sys_clk);
        check("t5_busy_mid_frame", int'(tx_busy), 1);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check("t5_tx_after_rst", int'(tx), 1);
        check("t5_busy_after_rst", int'(tx_busy), 0);
        check("t5_level_after_rst", int'(fifo_level), 0);
        check("t5_full_after_rst", int'(fifo_full), 0);
        sys_rst = 1'b0;
        l0 = low_cnt;
        b0 = busy_cnt;
        repeat (300) @(negedge sys_clk);
        check("t5_no_tx_low", low_cnt - l0, 0);
        check("t5_no_busy", busy_cnt - b0, 0);

        check("exp_queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
